fetch_ctrl: RTL and testbench

FETCH_CTRL -- requirements
Module: fetch_ctrl

---
 rtl/fetch_ctrl.sv | 154 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction fetch controller, one outstanding imem request.
// Define FETCH_CTRL_PERF_EN to add fetch_count/redirect_count outputs.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC      = 32'h0000_8000,
    parameter logic [1:0]  NOT_EXCEPTION = 2'b00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        jump,
    input  logic [31:0] c,
    input  logic [1:0]  exception_cause,
    input  logic [31:0] exception_handling_addr,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_ir,
    input  logic        if_ready
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] redirect_count
`endif
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT,
        FETCH,
        HOLD,
        KILL
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] addr_q;
    logic        req_q;
    logic        valid_q;
    logic [31:0] if_pc_q;
    logic [31:0] if_ir_q;

    logic        redirect_d;
    logic [31:0] target_d;
    logic        xfer_d;
    logic [31:0] pc_inc_d;

    assign redirect_d = jump || (exception_cause != NOT_EXCEPTION);
    assign target_d   = jump ? c : exception_handling_addr;
    assign xfer_d     = valid_q && if_ready && !stall;
    assign pc_inc_d   = pc_q + 32'd4;

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = valid_q;
    assign if_pc     = if_pc_q;
    assign if_ir     = if_ir_q;

    // Fetch sequencing; KILL waits out a stale response before refetching
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            if_pc_q <= 32'd0;
            if_ir_q <= NOP;
        end else begin
            unique case (state_q)
                BOOT: begin
                    state_q <= FETCH;
                    req_q   <= 1'b1;
                    valid_q <= 1'b0;
                    pc_q    <= redirect_d ? target_d : RESET_PC;
                    addr_q  <= redirect_d ? target_d : RESET_PC;
                end
                FETCH: begin
                    if (redirect_d) begin
                        pc_q    <= target_d;
                        valid_q <= 1'b0;
                        if (imem_ack) begin
                            addr_q <= target_d;
                        end else begin
                            state_q <= KILL;
                        end
                    end else if (imem_ack) begin
                        if_pc_q <= pc_q;
                        if_ir_q <= imem_rdata;
                        valid_q <= 1'b1;
                        pc_q    <= pc_inc_d;
                        if (xfer_d) begin
                            addr_q <= pc_inc_d;
                        end else begin
                            state_q <= HOLD;
                            req_q   <= 1'b0;
                        end
                    end else if (xfer_d) begin
                        valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redirect_d) begin
                        pc_q    <= target_d;
                        addr_q  <= target_d;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= FETCH;
                    end else if (xfer_d) begin
                        addr_q  <= pc_q;
                        valid_q <= 1'b0;
                        req_q   <= 1'b1;
                        state_q <= FETCH;
                    end
                end
                KILL: begin
                    if (imem_ack) begin
                        state_q <= FETCH;
                        pc_q    <= redirect_d ? target_d : pc_q;
                        addr_q  <= redirect_d ? target_d : pc_q;
                    end else if (redirect_d) begin
                        pc_q <= target_d;
                    end
                end
                default: begin
                    state_q <= BOOT;
                end
            endcase
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] redir_cnt_q;

    assign fetch_count    = fetch_cnt_q;
    assign redirect_count = redir_cnt_q;

    // Count accepted transfers and cycles with a redirect request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= 32'd0;
            redir_cnt_q <= 32'd0;
        end else begin
            if (xfer_d) fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (redirect_d) redir_cnt_q <= redir_cnt_q + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: randomized scoreboard bench for fetch_ctrl.
// Reference model tracks request/buffer/discard rules abstractly.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'h0000_8000;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        jump;
    logic [31:0] c;
    logic [1:0]  exc;
    logic [31:0] vec;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_ir;
    logic        if_ready;
    logic        ack_en;
    logic        ack_force;
`ifdef FETCH_CTRL_PERF_EN
    logic [31:0] fetch_count;
    logic [31:0] redirect_count;
`endif

    always #5 clk = ~clk;

    assign imem_ack = ack_force || (imem_req && ack_en);

    fetch_ctrl dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .stall                   (stall),
        .jump                    (jump),
        .c                       (c),
        .exception_cause         (exc),
        .exception_handling_addr (vec),
        .imem_req                (imem_req),
        .imem_addr               (imem_addr),
        .imem_ack                (imem_ack),
        .imem_rdata              (imem_rdata),
        .if_valid                (if_valid),
        .if_pc                   (if_pc),
        .if_ir                   (if_ir),
        .if_ready                (if_ready)
`ifdef FETCH_CTRL_PERF_EN
        ,
        .fetch_count             (fetch_count),
        .redirect_count          (redirect_count)
`endif
    );

    int n_chk  = 0;
    int n_fail = 0;
    int n_xfer = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model state
    logic        m_boot;
    logic        m_act;
    logic        m_drop;
    logic        m_bv;
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic [31:0] m_bpc;
    logic [31:0] m_bir;
    logic [63:0] exp_q[$];
    logic [31:0] req_log[$];
    logic [31:0] xpc_log[$];
    logic        p_req;
    logic [31:0] p_addr;
    int          pm_fetch;
    int          pm_redir;

    // Model: compare outputs, then advance using this cycle's inputs
    always @(negedge clk) begin
        logic        redir;
        logic [31:0] tgt;
        if (!rst_n) begin
            check("rst_req", 32'(imem_req), 32'd0);
            check("rst_addr", imem_addr, RESET_PC);
            check("rst_valid", 32'(if_valid), 32'd0);
            check("rst_pc", if_pc, 32'd0);
            check("rst_ir", if_ir, NOP);
            m_boot = 1'b1;
            m_act = 1'b0;
            m_drop = 1'b0;
            m_bv = 1'b0;
            m_pc = RESET_PC;
            m_addr = RESET_PC;
            exp_q.delete();
            pm_fetch = 0;
            pm_redir = 0;
            p_req = 1'b0;
            p_addr = 32'd0;
        end else begin
            check("req", 32'(imem_req), 32'(m_act));
            if (m_act) check("addr", imem_addr, m_addr);
            check("valid", 32'(if_valid), 32'(m_bv));
            if (m_bv) begin
                check("if_pc", if_pc, m_bpc);
                check("if_ir", if_ir, m_bir);
            end
            if (imem_req && (!p_req || imem_addr != p_addr))
                req_log.push_back(imem_addr);
            p_req = imem_req;
            p_addr = imem_addr;

            redir = jump || (exc != 2'b00);
            tgt = jump ? c : vec;
            if (redir) pm_redir++;
            if (m_bv && if_ready && !stall) begin
                exp_q.push_back({m_bpc, m_bir});
                pm_fetch++;
                m_bv = 1'b0;
            end
            if (m_boot) begin
                m_boot = 1'b0;
                if (redir) m_pc = tgt;
            end else begin
                if (m_act && imem_ack) begin
                    m_act = 1'b0;
                    if (!m_drop && !redir) begin
                        m_bv = 1'b1;
                        m_bpc = m_addr;
                        m_bir = imem_rdata;
                        m_pc = m_addr + 32'd4;
                    end
                end else if (m_act && redir) begin
                    m_drop = 1'b1;
                end
                if (redir) begin
                    m_pc = tgt;
                    m_bv = 1'b0;
                end
            end
            if (!m_act && !m_bv) begin
                m_act = 1'b1;
                m_addr = m_pc;
                m_drop = 1'b0;
            end
        end
    end

    // Monitor: every DUT transfer must match the next expected one
    always begin
        logic [63:0] e;
        @(negedge clk);
        #2;
        if (rst_n && if_valid && if_ready && !stall) begin
            n_xfer++;
            xpc_log.push_back(if_pc);
            if (exp_q.size() == 0) begin
                check("xfer_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("xfer_pc", if_pc, e[63:32]);
                check("xfer_ir", if_ir, e[31:0]);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        imem_rdata = $urandom;
    endtask

    task automatic wait_req(input string name);
        int k = 0;
        while (!imem_req && k < 20) begin
            cyc();
            k++;
        end
        check(name, 32'(imem_req), 32'd1);
    endtask

    initial begin
        logic [31:0] saved;
        logic        seen0;
        rst_n = 1'b0;
        stall = 1'b0;
        jump = 1'b0;
        c = 32'd0;
        exc = 2'b00;
        vec = 32'h40;
        if_ready = 1'b1;
        ack_en = 1'b1;
        ack_force = 1'b0;
        imem_rdata = 32'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Sequential fetch from reset
        repeat (12) cyc();
        for (int i = 0; i < 3; i++) begin
            if (req_log.size() > i)
                check("first_req", req_log[i], RESET_PC + 32'(4 * i));
            else
                check("first_req_missing", 32'd0, 32'd1);
            if (xpc_log.size() > i)
                check("first_xpc", xpc_log[i], RESET_PC + 32'(4 * i));
            else
                check("first_xpc_missing", 32'd0, 32'd1);
        end

        // Downstream back-pressure
        if_ready = 1'b0;
        repeat (6) cyc();
        check("hold_req", 32'(imem_req), 32'd0);
        check("hold_valid", 32'(if_valid), 32'd1);
        if_ready = 1'b1;
        repeat (3) cyc();

        // Jump while a request waits for ack
        ack_en = 1'b0;
        wait_req("kill_wait");
        saved = imem_addr;
        jump = 1'b1;
        c = 32'h100;
        cyc();
        jump = 1'b0;
        check("kill_addr", imem_addr, saved);
        check("kill_req", 32'(imem_req), 32'd1);
        cyc();
        cyc();
        ack_en = 1'b1;
        cyc();
        check("kill_redir", imem_addr, 32'h100);

        // Jump and exception together with ack
        ack_en = 1'b0;
        wait_req("both_wait");
        jump = 1'b1;
        c = 32'h200;
        exc = 2'b01;
        vec = 32'h40;
        ack_force = 1'b1;
        cyc();
        jump = 1'b0;
        exc = 2'b00;
        ack_force = 1'b0;
        check("both_addr", imem_addr, 32'h200);
        check("both_req", 32'(imem_req), 32'd1);
        ack_en = 1'b1;
        repeat (4) cyc();

        // Address wrap
        jump = 1'b1;
        c = 32'hFFFF_FFFC;
        cyc();
        jump = 1'b0;
        seen0 = 1'b0;
        for (int k = 0; k < 12; k++) begin
            cyc();
            if (imem_req && imem_addr == 32'd0) seen0 = 1'b1;
        end
        check("wrap_zero", 32'(seen0), 32'd1);

        // Random traffic
        for (int k = 0; k < 2000; k++) begin
            cyc();
            if_ready = ($urandom_range(3) != 0);
            stall = ($urandom_range(4) == 0);
            ack_en = ($urandom_range(1) == 1);
            jump = ($urandom_range(19) == 0);
            c = $urandom & 32'hFFFF_FFFC;
            exc = ($urandom_range(19) == 0) ?
                  2'($urandom_range(3, 1)) : 2'b00;
            vec = $urandom & 32'hFFFF_FFFC;
        end

        // Reset in the middle of a request, then a late ack
        stall = 1'b0;
        jump = 1'b0;
        exc = 2'b00;
        if_ready = 1'b1;
        ack_en = 1'b0;
        cyc();
        wait_req("rst_wait");
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_req", 32'(imem_req), 32'd0);
        check("async_addr", imem_addr, RESET_PC);
        check("async_valid", 32'(if_valid), 32'd0);
        ack_force = 1'b1;
        cyc();
        cyc();
        rst_n = 1'b1;
        cyc();
        ack_force = 1'b0;
        ack_en = 1'b1;
        check("boot_addr", imem_addr, RESET_PC);
        check("boot_valid", 32'(if_valid), 32'd0);
        for (int k = 0; k < 300; k++) begin
            cyc();
            if_ready = ($urandom_range(3) != 0);
            stall = ($urandom_range(5) == 0);
            ack_en = ($urandom_range(2) != 0);
            jump = ($urandom_range(29) == 0);
            c = $urandom & 32'hFFFF_FFFC;
            exc = ($urandom_range(29) == 0) ? 2'b10 : 2'b00;
        end

        // Drain
        stall = 1'b0;
        jump = 1'b0;
        exc = 2'b00;
        if_ready = 1'b0;
        repeat (3) cyc();
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("xfer_seen", 32'(n_xfer > 100), 32'd1);
`ifdef FETCH_CTRL_PERF_EN
        check("fetch_count", fetch_count, 32'(pm_fetch));
        check("redirect_count", redirect_count, 32'(pm_redir));
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
